reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//  Write-side producer for the 8x16 register file: merges ALU results and load returns into one
//  RegWrite/writeReg/writeValue stream, one write per cycle, in arrival order. Buffers bursts in a
//  DEPTH-entry FIFO, drops writes to r0 (hard zero), and keeps an 8-bit pending scoreboard so
//  decode can stall on RAW hazards. Sits between execute/memory and the register file.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of 2, >= 2)
//  W      16 data width
// PORTS
//  CLK          in   1   clock, all state updates on rising edge
//  Start        in   1   reset; asynchronous, active-high
//  alu_valid    in   1   ALU result offered this cycle
//  alu_dst      in   3   ALU destination register
//  alu_value    in   W   ALU result
//  alu_ready    out  1   ALU offer is accepted this cycle
//  mem_valid    in   1   load data offered this cycle
//  mem_dst      in   3   load destination register
//  mem_value    in   W   load data
//  mem_ready    out  1   load offer is accepted this cycle
//  issue_valid  in   1   decode issued an instruction that writes a register
//  issue_dst    in   3   its destination register
//  RegWrite     out  1   register file write enable (registered)
//  writeReg     out  3   register file write address (registered)
//  writeValue   out  W   register file write data (registered)
//  pending      out  8   bit i = write to ri outstanding (registered); bit 0 always 0
//  fifo_count   out  clog2(DEPTH)+1  entries queued (registered)
// BEHAVIOUR
//  Reset (Start=1, async): RegWrite=0, writeReg=0, writeValue=0, pending=0, fifo_count=0,
//   FIFO pointers 0. No output toggles while Start high; first edge after release is normal.
//  Ready: alu_ready = mem_ready = (fifo_count <= DEPTH-2), combinational from fifo_count only
//   (never from *_valid). Accept = valid & ready, sampled at rising edge.
//  r0: accepted offer with dst==0 is consumed and discarded; not queued, never output.
//  Per rising edge, in order:
//   1. pop = (fifo_count != 0). If pop: output regs <= FIFO head, RegWrite<=1.
//   2. Else if >=1 non-r0 accept: output <= mem offer if accepted, else ALU offer (bypass,
//      latency 1: offer at edge k -> RegWrite high for cycle k..k+1). RegWrite<=1.
//   3. Else RegWrite<=0; writeReg/writeValue hold last value.
//   4. Non-r0 accepts not bypassed are enqueued, mem before ALU when both same edge.
//   5. fifo_count <= fifo_count - pop + enq; ready rule guarantees never > DEPTH.
//  Ordering: FIFO order = acceptance order; same-edge tie: mem older than ALU.
//  RegWrite is a 1-cycle pulse per write; back-to-back writes keep RegWrite high with new
//   writeReg/writeValue each cycle.
//  Scoreboard, per edge: clear bit writeReg if RegWrite==1 (write completing this cycle);
//   set bit issue_dst if issue_valid & issue_dst!=0. Set wins when same bit set and cleared.
//   Issuing a register already pending keeps it pending; cleared at the first completing write
//   (issue logic must not issue a second write to a pending register).
//  Pointers wrap modulo DEPTH; full (count=DEPTH) and empty (count=0) both legal.
//  Reset mid-burst: all queued writes lost, pending cleared, no partial write emitted.
// TESTING
//  1. Reset: Start pulse mid-cycle -> RegWrite, pending, fifo_count 0 immediately, no edge needed.
//  2. ALU r3=0x1234 at edge 1, idle -> RegWrite=1,writeReg=3,writeValue=0x1234 cycle 1 only;
//     pending[3] set by issue at edge 0 clears at edge 2.
//  3. mem r5=0xAAAA and ALU r2=0x0055 same edge -> r5 written cycle 1, r2 cycle 2, count 1 then 0.
//  4. Both sources valid 4 consecutive edges, DEPTH=4 -> readies drop at count 3, no write lost,
//     8 writes emitted in order mem,alu,mem,alu..., count returns to 0, pointers wrap.
//  5. ALU dst=0 value 0xFFFF accepted -> no RegWrite, count unchanged, pending[0] stays 0.
//  6. issue_valid dst=4 on the edge RegWrite writes r4 -> pending[4]=1 after edge (set wins).

Source files
------------

// File: rtl/reg_writeback_if.sv
// Handshake and write-port bundle for the register write-back stage.
// The producer side (execute/memory/decode) uses the master modport,
// the write-back block itself uses the slave modport.
interface reg_writeback_if #(
    parameter int DEPTH = 4,
    parameter int W     = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // ALU result offer
    logic          alu_valid;
    logic [2:0]    alu_dst;
    logic [W-1:0]  alu_value;
    logic          alu_ready;

    // Load-return offer
    logic          mem_valid;
    logic [2:0]    mem_dst;
    logic [W-1:0]  mem_value;
    logic          mem_ready;

    // Decode issue notification for the hazard scoreboard
    logic          issue_valid;
    logic [2:0]    issue_dst;

    // Register file write port and status
    logic          RegWrite;
    logic [2:0]    writeReg;
    logic [W-1:0]  writeValue;
    logic [7:0]    pending;
    logic [CW-1:0] fifo_count;

    modport master (
        output alu_valid, alu_dst, alu_value,
        input  alu_ready,
        output mem_valid, mem_dst, mem_value,
        input  mem_ready,
        output issue_valid, issue_dst,
        input  RegWrite, writeReg, writeValue, pending, fifo_count
    );

    modport slave (
        input  alu_valid, alu_dst, alu_value,
        output alu_ready,
        input  mem_valid, mem_dst, mem_value,
        output mem_ready,
        input  issue_valid, issue_dst,
        output RegWrite, writeReg, writeValue, pending, fifo_count
    );
endinterface

// File: rtl/reg_writeback.sv
// Register write-back merger: folds ALU results and load returns into a
// single one-write-per-cycle stream for the 8x16 register file. Bursts are
// absorbed by a small FIFO, writes to r0 are swallowed, and a pending-write
// scoreboard is kept so decode can stall on read-after-write hazards.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic           CLK,
    input  logic           Start,
    reg_writeback_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0]   dst;
        logic [W-1:0] value;
    } entry_t;

    // State
    entry_t        store_reg [DEPTH];
    logic [AW-1:0] rptr_reg;
    logic [AW-1:0] wptr_reg;
    logic [CW-1:0] count_reg;
    logic          regwrite_reg;
    logic [2:0]    writereg_reg;
    logic [W-1:0]  writevalue_reg;
    logic [7:0]    pending_reg;

    // Next-state / datapath helpers
    logic          ready;
    logic          alu_acc;
    logic          mem_acc;
    logic          pop;
    logic          byp_valid;
    entry_t        byp_entry;
    entry_t        slot0;
    entry_t        slot1;
    logic [1:0]    enq_cnt;
    logic [AW-1:0] wptr_plus1;
    entry_t        head;
    logic          issue_set;
    logic [7:0]    pending_next;

    // Ready depends on occupancy only: leaving two free slots guarantees
    // that a same-edge pair of accepts always fits, even with no pop.
    assign ready         = (count_reg <= CW'(DEPTH - 2));
    assign bus.alu_ready = ready;
    assign bus.mem_ready = ready;

    // Offers to r0 are consumed (handshake completes) but carry no write.
    assign alu_acc = bus.alu_valid & ready & (bus.alu_dst != 3'd0);
    assign mem_acc = bus.mem_valid & ready & (bus.mem_dst != 3'd0);

    assign pop        = (count_reg != '0);
    assign head       = store_reg[rptr_reg];
    assign wptr_plus1 = wptr_reg + AW'(1);

    // Steer accepted writes: the FIFO head always has priority for the
    // output port; otherwise the older offer (mem) bypasses the queue and
    // whatever remains is enqueued in acceptance order, mem before ALU.
    always_comb begin
        byp_valid = 1'b0;
        byp_entry = '0;
        slot0     = '0;
        slot1     = '0;
        enq_cnt   = 2'd0;
        if (pop) begin
            if (mem_acc) begin
                slot0   = '{dst: bus.mem_dst, value: bus.mem_value};
                enq_cnt = 2'd1;
                if (alu_acc) begin
                    slot1   = '{dst: bus.alu_dst, value: bus.alu_value};
                    enq_cnt = 2'd2;
                end
            end else if (alu_acc) begin
                slot0   = '{dst: bus.alu_dst, value: bus.alu_value};
                enq_cnt = 2'd1;
            end
        end else if (mem_acc) begin
            byp_valid = 1'b1;
            byp_entry = '{dst: bus.mem_dst, value: bus.mem_value};
            if (alu_acc) begin
                slot0   = '{dst: bus.alu_dst, value: bus.alu_value};
                enq_cnt = 2'd1;
            end
        end else if (alu_acc) begin
            byp_valid = 1'b1;
            byp_entry = '{dst: bus.alu_dst, value: bus.alu_value};
        end
    end

    // Scoreboard next state, one bit per register. A new issue wins over a
    // completing write to the same register, so a back-to-back reissue
    // stays visible to decode. r0 can never be pending.
    assign issue_set       = bus.issue_valid & (bus.issue_dst != 3'd0);
    assign pending_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_sb
            always_comb begin
                pending_next[gi] = pending_reg[gi];
                if (regwrite_reg && (writereg_reg == 3'(gi)))
                    pending_next[gi] = 1'b0;
                if (issue_set && (bus.issue_dst == 3'(gi)))
                    pending_next[gi] = 1'b1;
            end
        end
    endgenerate

    // FIFO storage: up to two entries written per edge at wptr and wptr+1.
    // Contents need no reset; the pointers and count define validity.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if ((enq_cnt != 2'd0) && (wptr_reg == AW'(i)))
                store_reg[i] <= slot0;
            else if ((enq_cnt == 2'd2) && (wptr_plus1 == AW'(i)))
                store_reg[i] <= slot1;
        end
    end

    // Control state, write port and scoreboard registers.
    always_ff @(posedge CLK or posedge Start) begin
        if (Start) begin
            rptr_reg       <= '0;
            wptr_reg       <= '0;
            count_reg      <= '0;
            regwrite_reg   <= 1'b0;
            writereg_reg   <= 3'd0;
            writevalue_reg <= '0;
            pending_reg    <= 8'd0;
        end else begin
            if (pop) begin
                regwrite_reg   <= 1'b1;
                writereg_reg   <= head.dst;
                writevalue_reg <= head.value;
                rptr_reg       <= rptr_reg + AW'(1);
            end else if (byp_valid) begin
                regwrite_reg   <= 1'b1;
                writereg_reg   <= byp_entry.dst;
                writevalue_reg <= byp_entry.value;
            end else begin
                regwrite_reg   <= 1'b0;
            end
            wptr_reg    <= wptr_reg + AW'(enq_cnt);
            count_reg   <= count_reg - CW'(pop) + CW'(enq_cnt);
            pending_reg <= pending_next;
        end
    end

    assign bus.RegWrite   = regwrite_reg;
    assign bus.writeReg   = writereg_reg;
    assign bus.writeValue = writevalue_reg;
    assign bus.pending    = pending_reg;
    assign bus.fifo_count = count_reg;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset, single bypass write, same-edge
// ordering, a four-pair burst that exercises back-pressure and pointer wrap,
// r0 discard, and scoreboard set-over-clear.
module tb_reg_writeback;
    localparam int DEPTH = 4;
    localparam int W     = 16;

    logic clk;
    logic start;
    int   checks;
    int   failures;

    reg_writeback_if #(.DEPTH(DEPTH), .W(W)) bus ();

    reg_writeback #(.DEPTH(DEPTH), .W(W)) dut (
        .CLK   (clk),
        .Start (start),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_dst     = 3'd0;
        bus.alu_value   = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_dst     = 3'd0;
        bus.mem_value   = '0;
        bus.issue_valid = 1'b0;
        bus.issue_dst   = 3'd0;
    endtask

    task automatic test_reset();
        // Values right after the power-on reset.
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.writeReg !== 3'd0 || bus.writeValue !== 16'h0000 ||
            bus.pending !== 8'h00 || bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_initial: got we=%b reg=%0d val=%h pend=%h cnt=%0d, want all 0",
                     bus.RegWrite, bus.writeReg, bus.writeValue, bus.pending, bus.fifo_count);
        end
        // Build some state: mem r2 + ALU r1 on one edge, issue r7.
        bus.mem_valid = 1'b1; bus.mem_dst = 3'd2; bus.mem_value = 16'h2222;
        bus.alu_valid = 1'b1; bus.alu_dst = 3'd1; bus.alu_value = 16'h1111;
        bus.issue_valid = 1'b1; bus.issue_dst = 3'd7;
        tick();
        idle_inputs();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.fifo_count !== 3'd1 || bus.pending !== 8'h80) begin
            failures++;
            $display("FAIL reset_setup: got we=%b cnt=%0d pend=%h, want we=1 cnt=1 pend=80",
                     bus.RegWrite, bus.fifo_count, bus.pending);
        end
        // Mid-cycle asynchronous reset.
        #3;
        start = 1'b1;
        #1;
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.writeReg !== 3'd0 || bus.writeValue !== 16'h0000 ||
            bus.pending !== 8'h00 || bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_async: got we=%b reg=%0d val=%h pend=%h cnt=%0d, want all 0",
                     bus.RegWrite, bus.writeReg, bus.writeValue, bus.pending, bus.fifo_count);
        end
        #2;
        start = 1'b0;
        tick();
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_after: got we=%b cnt=%0d, want we=0 cnt=0 (queued write lost)",
                     bus.RegWrite, bus.fifo_count);
        end
    endtask

    task automatic test_alu_single();
        bus.issue_valid = 1'b1; bus.issue_dst = 3'd3;
        tick();
        bus.issue_valid = 1'b0;
        checks++;
        if (bus.pending !== 8'h08 || bus.RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL single_issue: got pend=%h we=%b, want pend=08 we=0",
                     bus.pending, bus.RegWrite);
        end
        bus.alu_valid = 1'b1; bus.alu_dst = 3'd3; bus.alu_value = 16'h1234;
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got alu_ready=%b mem_ready=%b, want 1 1",
                     bus.alu_ready, bus.mem_ready);
        end
        tick();
        bus.alu_valid = 1'b0;
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.writeReg !== 3'd3 || bus.writeValue !== 16'h1234 ||
            bus.pending !== 8'h08) begin
            failures++;
            $display("FAIL single_write: got we=%b reg=%0d val=%h pend=%h, want 1 3 1234 08",
                     bus.RegWrite, bus.writeReg, bus.writeValue, bus.pending);
        end
        tick();
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.writeReg !== 3'd3 || bus.writeValue !== 16'h1234 ||
            bus.pending !== 8'h00) begin
            failures++;
            $display("FAIL single_after: got we=%b reg=%0d val=%h pend=%h, want 0 3 1234 00",
                     bus.RegWrite, bus.writeReg, bus.writeValue, bus.pending);
        end
    endtask

    task automatic test_same_edge();
        bus.mem_valid = 1'b1; bus.mem_dst = 3'd5; bus.mem_value = 16'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_dst = 3'd2; bus.alu_value = 16'h0055;
        tick();
        idle_inputs();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.writeReg !== 3'd5 || bus.writeValue !== 16'hAAAA ||
            bus.fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL same_edge_first: got we=%b reg=%0d val=%h cnt=%0d, want 1 5 aaaa 1",
                     bus.RegWrite, bus.writeReg, bus.writeValue, bus.fifo_count);
        end
        tick();
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.writeReg !== 3'd2 || bus.writeValue !== 16'h0055 ||
            bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL same_edge_second: got we=%b reg=%0d val=%h cnt=%0d, want 1 2 0055 0",
                     bus.RegWrite, bus.writeReg, bus.writeValue, bus.fifo_count);
        end
        tick();
        checks++;
        if (bus.RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL same_edge_idle: got we=%b, want 0", bus.RegWrite);
        end
    endtask

    task automatic test_burst();
        logic [18:0] exp_q[$];
        logic [18:0] exp_e;
        int k = 0;
        int writes = 0;
        int cycles = 0;
        int max_cnt = 0;
        logic saw_drop = 1'b0;
        logic acc;
        while (k < 4 || exp_q.size() != 0 || bus.fifo_count != 0) begin
            if (k < 4) begin
                bus.mem_valid = 1'b1; bus.mem_dst = 3'd1; bus.mem_value = 16'hA000 + 16'(k);
                bus.alu_valid = 1'b1; bus.alu_dst = 3'd6; bus.alu_value = 16'hB000 + 16'(k);
            end else begin
                idle_inputs();
            end
            acc = (k < 4) && bus.alu_ready;
            if (k < 4 && bus.alu_ready === 1'b0) begin
                saw_drop = 1'b1;
                checks++;
                if (bus.fifo_count !== 3'd3 || bus.mem_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL burst_ready_drop: got cnt=%0d mem_ready=%b, want cnt=3 mem_ready=0",
                             bus.fifo_count, bus.mem_ready);
                end
            end
            if (acc) begin
                exp_q.push_back({3'd1, 16'hA000 + 16'(k)});
                exp_q.push_back({3'd6, 16'hB000 + 16'(k)});
                k++;
            end
            tick();
            if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
            if (bus.RegWrite === 1'b1) begin
                writes++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL burst_extra_write: got reg=%0d val=%h, want no write",
                             bus.writeReg, bus.writeValue);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({bus.writeReg, bus.writeValue} !== exp_e) begin
                        failures++;
                        $display("FAIL burst_order: got reg=%0d val=%h, want reg=%0d val=%h",
                                 bus.writeReg, bus.writeValue, exp_e[18:16], exp_e[15:0]);
                    end
                end
            end
            cycles++;
            if (cycles > 40) begin
                failures++;
                $display("FAIL burst_timeout: got %0d writes after %0d cycles, want 8", writes, cycles);
                break;
            end
        end
        idle_inputs();
        checks++;
        if (writes != 8 || !saw_drop || max_cnt != 3 || bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL burst_summary: got writes=%0d drop=%b maxcnt=%0d cnt=%0d, want 8 1 3 0",
                     writes, saw_drop, max_cnt, bus.fifo_count);
        end
    endtask

    task automatic test_r0();
        bus.alu_valid = 1'b1; bus.alu_dst = 3'd0; bus.alu_value = 16'hFFFF;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL r0_ready: got alu_ready=%b, want 1", bus.alu_ready);
        end
        tick();
        bus.alu_valid = 1'b0;
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.fifo_count !== 3'd0 || bus.pending[0] !== 1'b0) begin
            failures++;
            $display("FAIL r0_discard: got we=%b cnt=%0d pend0=%b, want 0 0 0",
                     bus.RegWrite, bus.fifo_count, bus.pending[0]);
        end
        tick();
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL r0_later: got we=%b cnt=%0d, want 0 0", bus.RegWrite, bus.fifo_count);
        end
    endtask

    task automatic test_set_wins();
        bus.issue_valid = 1'b1; bus.issue_dst = 3'd4;
        bus.alu_valid = 1'b1; bus.alu_dst = 3'd4; bus.alu_value = 16'h4444;
        tick();
        bus.alu_valid = 1'b0;
        // issue_valid stays high for r4 across the edge where r4 is written
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.writeReg !== 3'd4 || bus.pending !== 8'h10) begin
            failures++;
            $display("FAIL setwin_write: got we=%b reg=%0d pend=%h, want 1 4 10",
                     bus.RegWrite, bus.writeReg, bus.pending);
        end
        tick();
        bus.issue_valid = 1'b0;
        checks++;
        if (bus.pending !== 8'h10 || bus.RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL setwin_pending: got pend=%h we=%b, want pend=10 we=0",
                     bus.pending, bus.RegWrite);
        end
        bus.alu_valid = 1'b1; bus.alu_dst = 3'd4; bus.alu_value = 16'h4445;
        tick();
        bus.alu_valid = 1'b0;
        tick();
        checks++;
        if (bus.pending !== 8'h00 || bus.writeValue !== 16'h4445) begin
            failures++;
            $display("FAIL setwin_clear: got pend=%h val=%h, want pend=00 val=4445",
                     bus.pending, bus.writeValue);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #3;
        start = 1'b0;
        tick();
        test_reset();
        test_alu_single();
        test_same_edge();
        test_burst();
        test_r0();
        test_set_wins();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
